// File: rtl/lsu_mem_port.sv
// Data-memory initiator port: one load/store at a time, aligned accesses issued whole,
// misaligned half/word accesses split into byte accesses and reassembled little-endian.
module lsu_mem_port #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    input  logic [31:0] mem_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state, w_state_n;
    logic        r_write, w_write_n;
    logic [1:0]  r_size, w_size_n;
    logic        r_unsigned, w_unsigned_n;
    logic [31:0] r_addr, w_addr_n;
    logic [31:0] r_wdata, w_wdata_n;
    logic        r_misal, w_misal_n;
    logic [1:0]  r_idx, w_idx_n;
    logic [31:0] r_asm, w_asm_n;
    logic        r_req_ready, w_req_ready_n;
    logic        r_resp_valid, w_resp_valid_n;
    logic [31:0] r_resp_rdata, w_resp_rdata_n;
    logic        r_resp_err, w_resp_err_n;
    logic [31:0] r_mem_addr, w_mem_addr_n;
    logic [31:0] r_mem_data, w_mem_data_n;
    logic        r_mem_read, w_mem_read_n;
    logic        r_mem_write, w_mem_write_n;
    logic [1:0]  r_mem_size, w_mem_size_n;
    logic        r_mem_unsigned, w_mem_unsigned_n;
    logic [2:0]  w_req_nbytes, w_cur_nbytes;
    logic [32:0] w_req_end;
    logic        w_fault, w_last;

    function automatic logic [2:0] f_nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   f_nbytes = 3'd1;
            2'b01:   f_nbytes = 3'd2;
            2'b10:   f_nbytes = 3'd4;
            default: f_nbytes = 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_extend(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        case (sz)
            2'b01:   f_extend = {(uns ? 16'h0000 : {16{a[15]}}), a[15:0]};
            default: f_extend = a;
        endcase
    endfunction

    // Request decode: byte count, range/size fault and last split byte
    always_comb begin
        w_req_nbytes = f_nbytes(req_size);
        w_cur_nbytes = f_nbytes(r_size);
        w_req_end    = {1'b0, req_addr} + {30'b0, w_req_nbytes} - 33'd1;
        w_fault      = (req_size == 2'b11) || (w_req_end >= 33'(MEM_BYTES));
        w_last       = (r_idx == (w_cur_nbytes[1:0] - 2'd1));
    end

    // Next-state, request latches, load assembly and response values
    always_comb begin
        w_state_n      = r_state;
        w_write_n      = r_write;
        w_size_n       = r_size;
        w_unsigned_n   = r_unsigned;
        w_addr_n       = r_addr;
        w_wdata_n      = r_wdata;
        w_misal_n      = r_misal;
        w_idx_n        = r_idx;
        w_asm_n        = r_asm;
        w_resp_rdata_n = r_resp_rdata;
        w_resp_err_n   = r_resp_err;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_write_n    = req_write;
                    w_size_n     = req_size;
                    w_unsigned_n = req_unsigned;
                    w_addr_n     = req_addr;
                    w_wdata_n    = req_wdata;
                    w_idx_n      = 2'd0;
                    w_asm_n      = 32'h0000_0000;
                    w_misal_n    = ((req_size == 2'b01) && req_addr[0]) ||
                                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
                    if (w_fault) begin
                        w_state_n      = ST_RESP;
                        w_resp_err_n   = 1'b1;
                        w_resp_rdata_n = 32'h0000_0000;
                    end else begin
                        w_state_n = ST_ACCESS;
                    end
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_misal) begin
                    if (!r_write) begin
                        w_asm_n[{r_idx, 3'b000} +: 8] = mem_out[7:0];
                    end else begin
                        w_asm_n = r_asm;
                    end
                    if (w_last) begin
                        w_state_n      = ST_RESP;
                        w_resp_err_n   = 1'b0;
                        w_resp_rdata_n = r_write ? 32'h0000_0000 : f_extend(w_asm_n, r_size, r_unsigned);
                    end else begin
                        w_idx_n = r_idx + 2'd1;
                    end
                end else begin
                    // the memory already sized and extended an aligned load
                    w_asm_n        = r_write ? r_asm : mem_out;
                    w_state_n      = ST_RESP;
                    w_resp_err_n   = 1'b0;
                    w_resp_rdata_n = r_write ? 32'h0000_0000 : mem_out;
                end
            end
            ST_RESP: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Output values for the cycle after the edge, derived from the next state
    always_comb begin
        w_req_ready_n    = (w_state_n == ST_IDLE);
        w_resp_valid_n   = (w_state_n == ST_RESP);
        w_mem_addr_n     = 32'h0000_0000;
        w_mem_data_n     = 32'h0000_0000;
        w_mem_read_n     = 1'b0;
        w_mem_write_n    = 1'b0;
        w_mem_size_n     = 2'b00;
        w_mem_unsigned_n = 1'b0;
        if (w_state_n == ST_ACCESS) begin
            w_mem_read_n  = !w_write_n;
            w_mem_write_n = w_write_n;
            if (w_misal_n) begin
                w_mem_addr_n     = w_addr_n + {30'b0, w_idx_n};
                w_mem_size_n     = 2'b00;
                w_mem_unsigned_n = 1'b1;
                w_mem_data_n     = {24'h000000, w_wdata_n[{w_idx_n, 3'b000} +: 8]};
            end else begin
                w_mem_addr_n     = w_addr_n;
                w_mem_size_n     = w_size_n;
                w_mem_unsigned_n = w_unsigned_n;
                w_mem_data_n     = w_wdata_n;
            end
        end else begin
            w_mem_read_n  = 1'b0;
            w_mem_write_n = 1'b0;
        end
    end

    // State, latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_addr         <= 32'h0000_0000;
            r_wdata        <= 32'h0000_0000;
            r_misal        <= 1'b0;
            r_idx          <= 2'd0;
            r_asm          <= 32'h0000_0000;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 32'h0000_0000;
            r_resp_err     <= 1'b0;
            r_mem_addr     <= 32'h0000_0000;
            r_mem_data     <= 32'h0000_0000;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_size     <= 2'b00;
            r_mem_unsigned <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_write        <= w_write_n;
            r_size         <= w_size_n;
            r_unsigned     <= w_unsigned_n;
            r_addr         <= w_addr_n;
            r_wdata        <= w_wdata_n;
            r_misal        <= w_misal_n;
            r_idx          <= w_idx_n;
            r_asm          <= w_asm_n;
            r_req_ready    <= w_req_ready_n;
            r_resp_valid   <= w_resp_valid_n;
            r_resp_rdata   <= w_resp_rdata_n;
            r_resp_err     <= w_resp_err_n;
            r_mem_addr     <= w_mem_addr_n;
            r_mem_data     <= w_mem_data_n;
            r_mem_read     <= w_mem_read_n;
            r_mem_write    <= w_mem_write_n;
            r_mem_size     <= w_mem_size_n;
            r_mem_unsigned <= w_mem_unsigned_n;
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign mem_size     = r_mem_size;
    assign mem_unsigned = r_mem_unsigned;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array memory, directed scenarios and random requests
// checked against a byte-level reference memory and per-request expected bus accesses.
module tb_lsu_mem_port;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_data, mem_out;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;

    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        bd_we, bd_clr;
    logic [31:0] bd_addr;
    logic [7:0]  bd_data;
    logic [31:0] w_word;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_a[$], exp_d[$], obs_a[$], obs_d[$];
    logic [4:0]  exp_k[$], obs_k[$];

    always #5 clk = ~clk;

    lsu_mem_port #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_out(mem_out)
    );

    // Combinational memory read with size/extension handling
    always_comb begin
        w_word = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (mem_addr + 32'(b) < 32'(MEM_BYTES)) w_word[8*b +: 8] = mem[int'(mem_addr) + b];
        end
        if (!mem_read) mem_out = 32'h0;
        else begin
            case (mem_size)
                2'b00:   mem_out = mem_unsigned ? {24'h0, w_word[7:0]} : {{24{w_word[7]}}, w_word[7:0]};
                2'b01:   mem_out = mem_unsigned ? {16'h0, w_word[15:0]} : {{16{w_word[15]}}, w_word[15:0]};
                default: mem_out = w_word;
            endcase
        end
    end

    // Memory writes on the rising edge, plus backdoor clear/load
    always @(posedge clk) begin
        if (bd_clr) begin
            for (int j = 0; j < MEM_BYTES; j++) mem[j] <= 8'h00;
        end else if (bd_we) begin
            mem[int'(bd_addr)] <= bd_data;
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if ((b == 0 || (b == 1 && mem_size != 2'b00) || (b >= 2 && mem_size == 2'b10)) &&
                    (mem_addr + 32'(b) < 32'(MEM_BYTES)))
                    mem[int'(mem_addr) + b] <= mem_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[int'(a)] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic bd_word(input logic [31:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) bd_write(a + 32'(b), w[8*b +: 8]);
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({pfx, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
        chk({pfx, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({pfx, "_resp_err"}, {31'h0, resp_err}, 32'h0);
        chk({pfx, "_mem_rw"}, {30'h0, mem_read, mem_write}, 32'h0);
        chk({pfx, "_mem_addr"}, mem_addr, 32'h0);
        chk({pfx, "_mem_data"}, mem_data, 32'h0);
        chk({pfx, "_mem_size_uns"}, {29'h0, mem_size, mem_unsigned}, 32'h0);
    endtask

    // One request: model expectations, drive, monitor until response, compare
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic [31:0] o_rd, output logic o_err);
        int n, exp_lat, k;
        logic exp_err, mis;
        logic [31:0] exp_rd;
        logic [63:0] val, endb;
        bit got, busy_ready;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_a.delete(); exp_d.delete(); exp_k.delete();
        endb = {32'h0, ad} + 64'(n) - 64'd1;
        if (sz == 2'b11 || endb >= 64'(MEM_BYTES)) begin
            exp_err = 1'b1; exp_rd = 32'h0; exp_lat = 1;
        end else begin
            mis = (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
            exp_err = 1'b0;
            exp_lat = mis ? 1 + n : 2;
            val = 64'h0;
            for (int b = 0; b < n; b++) val = val | (64'(ref_mem[int'(ad) + b]) << (8*b));
            if (wr) begin
                for (int b = 0; b < n; b++) ref_mem[int'(ad) + b] = wd[8*b +: 8];
                exp_rd = 32'h0;
            end else begin
                if (!un && val[8*n-1]) val = val | (~64'h0 << (8*n));
                exp_rd = val[31:0];
            end
            if (mis) begin
                for (int b = 0; b < n; b++) begin
                    exp_a.push_back(ad + 32'(b));
                    exp_d.push_back({24'h0, wd[8*b +: 8]});
                    exp_k.push_back({wr, !wr, 2'b00, 1'b1});
                end
            end else begin
                exp_a.push_back(ad); exp_d.push_back(wd); exp_k.push_back({wr, !wr, sz, un});
            end
        end
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        chk("ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        obs_a.delete(); obs_d.delete(); obs_k.delete();
        got = 1'b0; busy_ready = 1'b0; k = 0; o_rd = 32'h0; o_err = 1'b0;
        while (!got && k < 16) begin
            @(negedge clk);
            k++;
            if (req_ready) busy_ready = 1'b1;
            if (mem_read || mem_write) begin
                obs_a.push_back(mem_addr); obs_d.push_back(mem_data);
                obs_k.push_back({mem_write, mem_read, mem_size, mem_unsigned});
            end
            if (resp_valid) begin
                got = 1'b1; o_rd = resp_rdata; o_err = resp_err;
            end
        end
        chk("resp_seen", 32'(got), 32'h1);
        chk("latency", k, exp_lat);
        chk("resp_err", {31'h0, o_err}, {31'h0, exp_err});
        chk("resp_rdata", o_rd, exp_rd);
        chk("ready_busy", 32'(busy_ready), 32'h0);
        chk("n_access", obs_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            chk("acc_addr", obs_a[i], exp_a[i]);
            chk("acc_data", obs_d[i], exp_d[i]);
            chk("acc_kind", {27'h0, obs_k[i]}, {27'h0, exp_k[i]});
        end
        @(negedge clk);
        chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
        chk("ready_back", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ad;
        int          wcnt, k, bad;
        bit          seen;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        bd_we = 1'b0; bd_addr = 32'h0; bd_data = 8'h0; bd_clr = 1'b1;
        for (int j = 0; j < MEM_BYTES; j++) ref_mem[j] = 8'h00;
        @(posedge clk);
        #1 bd_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int a = 32'h0F0; a < 32'h180; a++) bd_write(32'(a), 8'($urandom));
        for (int a = MEM_BYTES - 16; a < MEM_BYTES; a++) bd_write(32'(a), 8'($urandom));
        bd_word(32'h100, 32'h1122_3344);
        bd_word(32'h104, 32'h5566_7788);

        run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er);
        chk("tp_lw100", rd, 32'h1122_3344);
        run_txn(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, rd, er);
        chk("tp_lh103_s", rd, 32'hFFFF_8811);
        run_txn(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, rd, er);
        chk("tp_lh103_u", rd, 32'h0000_8811);
        run_txn(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, rd, er);
        chk("tp_lb102", rd, 32'h0000_0022);

        // back-to-back: request held high, address changed while busy
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_access", {31'h0, req_ready}, 32'h0);
        req_addr = 32'h104;
        @(negedge clk);
        chk("b2b_ready_resp", {31'h0, req_ready}, 32'h0);
        chk("b2b_first_rdata", resp_valid ? resp_rdata : 32'hDEAD_BEEF, 32'h1122_3344);
        @(negedge clk);
        chk("b2b_ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_addr", mem_addr, 32'h104);
        chk("b2b_second_read", {31'h0, mem_read}, 32'h1);
        @(negedge clk);
        chk("b2b_second_rdata", resp_valid ? resp_rdata : 32'hDEAD_BEEF, 32'h5566_7788);

        run_txn(1'b1, 2'b10, 1'b0, 32'h101, 32'hAABB_CCDD, rd, er);
        run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er);
        chk("tp_lw100_after", rd, 32'hBBCC_DD44);
        run_txn(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, rd, er);
        chk("tp_lw104_after", rd, 32'h5566_77AA);
        run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er);
        chk("tp_size11_err", {31'h0, er}, 32'h1);
        run_txn(1'b0, 2'b10, 1'b0, 32'(MEM_BYTES - 2), 32'h0, rd, er);
        chk("tp_range_err", {31'h0, er}, 32'h1);
        run_txn(1'b0, 2'b10, 1'b1, 32'(MEM_BYTES - 4), 32'h0, rd, er);
        run_txn(1'b0, 2'b01, 1'b0, 32'(MEM_BYTES - 1), 32'h0, rd, er);
        run_txn(1'b0, 2'b00, 1'b0, 32'(MEM_BYTES - 1), 32'h0, rd, er);
        run_txn(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, rd, er);

        // reset in the middle of a split store
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h101;
        req_wdata = 32'h1234_5678; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wcnt = 0; k = 0;
        while (wcnt < 2 && k < 10) begin
            @(negedge clk);
            k++;
            if (mem_write) wcnt++;
        end
        chk("abort_writes_seen", wcnt, 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_state("abort");
        ref_mem[32'h101] = 8'h78;
        ref_mem[32'h102] = 8'h56;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_write || resp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_write || resp_valid) seen = 1'b1;
        end
        chk("abort_quiet", 32'(seen), 32'h0);
        chk("abort_idle", {31'h0, req_ready}, 32'h1);
        chk("abort_b101", {24'h0, mem[32'h101]}, 32'h78);
        chk("abort_b102", {24'h0, mem[32'h102]}, 32'h56);
        chk("abort_b103", {24'h0, mem[32'h103]}, 32'hBB);
        chk("abort_b104", {24'h0, mem[32'h104]}, 32'hAA);

        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 9))
                0:       ad = $urandom;
                1, 2:    ad = 32'(MEM_BYTES) - 32'($urandom_range(1, 6));
                default: ad = 32'h100 + 32'($urandom_range(0, 63));
            endcase
            run_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ad, $urandom, rd, er);
        end

        bad = 0;
        for (int j = 0; j < MEM_BYTES; j++) if (mem[j] !== ref_mem[j]) bad++;
        chk("mem_image", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Initiator side of the data-memory port. Accepts one load/store request at a time from the execute stage over a valid/ready handshake, then drives the memory's addr/data/read/write/size/unsigned interface. Natively aligned accesses are issued as a single access. Misaligned halfword/word accesses are split into sequential byte accesses, and the load result is reassembled and extended. Returns one response per request to writeback; size and range faults are answered without touching memory.

Parameters:
MEM_BYTES, 4096, addressable bytes of the attached data memory (multiple of 4).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, low bytes significant
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result (0 for stores and faults)
resp_err  out  1  fault flag, valid with resp_valid
mem_addr  out  32  byte address to memory
mem_data  out  32  write data to memory
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable (memory writes on rising edge)
mem_size  out  2  access size to memory
mem_unsigned  out  1  extension mode to memory
mem_out  in  32  combinational read data from memory

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; all mem_* outputs 0; internal latches cleared.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Fault path: IDLE -> RESP directly.
- IDLE: mem_read=mem_write=0, all mem_* = 0. On accept, latch write, size, unsigned, addr, wdata. Clear byte index i and the assembly register.
- Byte count N: 1, 2 or 4 for size 00, 01, 10.
- Fault: size==11, or (33-bit) addr+N-1 >= MEM_BYTES. Go to RESP with resp_err=1, resp_rdata=0. No mem_read/mem_write is asserted.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Byte accesses are never misaligned.
- Aligned ACCESS: exactly one cycle. mem_addr=addr, mem_size=size, mem_unsigned=unsigned, mem_read=!write, mem_write=write, mem_data=wdata. A load registers mem_out at the end of this cycle.
- Split ACCESS: N cycles, i=0..N-1. Each cycle: mem_addr=addr+i, mem_size=00, mem_unsigned=1, mem_data={24'b0, wdata[8i+7:8i]}.
  - Load: mem_out[7:0] is captured into assembly bits [8i+7:8i].
  - i increments each cycle; leave ACCESS after i==N-1.
- Split load result: half -> bits[31:16] = unsigned ? 0 : replicated bit15. Word -> used as assembled. Little-endian order throughout.
- RESP: resp_valid=1 for exactly one cycle; req_ready=0; mem_read=mem_write=0. resp_rdata holds the load result, or 0 for stores. resp_err=0 unless faulted. Next state is IDLE.
- Latency from accept edge T: aligned response in cycle T+2; split response in cycle T+1+N; fault response in cycle T+1.
- Throughput: the next request is accepted no earlier than the RESP->IDLE edge. req_valid in non-IDLE states is ignored, with no queuing.
- Address arithmetic addr+i is 32-bit. Wrap cannot occur because the range check rejects it first.
- resp_rdata/resp_err hold their last value outside RESP; sampling is qualified by resp_valid only.
- Reset mid-ACCESS: immediate return to IDLE with all outputs at reset values. No further memory writes occur. Bytes already written stay in memory, and no response is issued for the aborted request.

Test Plan:
- Preload mem[0x100]=0x11223344, mem[0x104]=0x55667788. Load word 0x100 -> one mem_read cycle with mem_size=10; resp_valid at T+2, rdata=0x11223344, err=0.
- Load half signed 0x103 -> 2 byte reads at 0x103, 0x104; resp at T+3, rdata=0xFFFF8811. Same load unsigned -> 0x00008811.
- Store word 0xAABBCCDD at 0x101 -> 4 byte writes at 0x101..0x104 with mem_data 0xDD,0xCC,0xBB,0xAA; resp at T+5. Then load word 0x100 -> 0xBBCCDD44, load word 0x104 -> 0x556677AA.
- size=11 at 0x100 -> resp at T+1, err=1, rdata=0, mem_read and mem_write never asserted. Load word at MEM_BYTES-2 -> same fault.
- Load byte signed 0x102 -> aligned single access with mem_size=00, mem_unsigned=0; rdata equals the memory's 0x00000022. Back-to-back req_valid -> req_ready low in ACCESS and RESP, second request accepted at T+3.
- Misaligned word store at 0x101; assert rst_n=0 after the 2nd byte write -> no further mem_write and no resp_valid. Bytes at 0x101, 0x102 updated, bytes at 0x103, 0x104 unchanged; FSM in IDLE after release.
